// File: rtl/mpu_pkg.sv
// Shared MPU definitions: op encodings, element-wise engine states and
// element range helpers.
package mpu_pkg;

  localparam logic MPU_OP_ADD = 1'b0;
  localparam logic MPU_OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mpu_ew_state_t;

  // Largest representable element value. The caller slices the low w bits.
  function automatic logic [63:0] elem_max(input int w, input bit s);
    if (s) return (64'd1 << (w - 1)) - 64'd1;
    else   return (64'd1 << w) - 64'd1;
  endfunction

  // Smallest representable element value. Upper bits are all ones in the
  // signed case, so the low w bits read as 100..0.
  function automatic logic [63:0] elem_min(input int w, input bit s);
    if (s) return ~((64'd1 << (w - 1)) - 64'd1);
    else   return 64'd0;
  endfunction

endpackage

// File: rtl/mpu_row_alu.sv
// Combinational row ALU: N element lanes of add/sub with overflow detect
// and optional saturation, plus an OR-reduced row overflow flag.
module mpu_row_alu
  import mpu_pkg::*;
#(
  parameter int N      = 5,
  parameter int W      = 8,
  parameter int SIGNED = 0
) (
  input  logic [N*W-1:0] row_a,
  input  logic [N*W-1:0] row_b,
  input  logic           op,
  input  logic           sat,
  output logic [N*W-1:0] row_res,
  output logic           row_ovf
);

  localparam logic [W-1:0] MAXV = W'(elem_max(W, SIGNED != 0));
  localparam logic [W-1:0] MINV = W'(elem_min(W, SIGNED != 0));

  logic [N-1:0] ovf_vec;

  for (genvar g = 0; g < N; g++) begin : g_lane
    logic [W-1:0] ea, eb, clamp;
    logic [W:0]   xa, xb, sum;
    logic         ov;

    assign ea = row_a[g*W +: W];
    assign eb = row_b[g*W +: W];

    if (SIGNED != 0) begin : g_s
      // Sign-extended W+1 result: overflow when the two top bits disagree.
      // Out-of-range results always lean the way operand a points.
      assign xa    = {ea[W-1], ea};
      assign xb    = {eb[W-1], eb};
      assign ov    = sum[W] ^ sum[W-1];
      assign clamp = ea[W-1] ? MINV : MAXV;
    end else begin : g_u
      // Zero-extended: bit W is the carry on add and the borrow on sub.
      assign xa    = {1'b0, ea};
      assign xb    = {1'b0, eb};
      assign ov    = sum[W];
      assign clamp = (op == MPU_OP_SUB) ? MINV : MAXV;
    end

    assign sum = (op == MPU_OP_SUB) ? (xa - xb) : (xa + xb);
    assign row_res[g*W +: W] = (ov && sat) ? clamp : sum[W-1:0];
    assign ovf_vec[g] = ov;
  end

  assign row_ovf = |ovf_vec;

endmodule

// File: rtl/mpu_elementwise_engine.sv
// Sequential N x N element-wise engine: latches both operands on start,
// then pushes one row per clock through a shared row ALU.
module mpu_elementwise_engine
  import mpu_pkg::*;
#(
  parameter int N      = 5,
  parameter int W      = 8,
  parameter int SIGNED = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic             sat,
  input  logic [N*N*W-1:0] matrix_a,
  input  logic [N*N*W-1:0] matrix_b,
  output logic [N*N*W-1:0] result,
  output logic             busy,
  output logic             done,
  output logic             overflow
);

  localparam int RW       = N * W;
  localparam int ROW_BITS = $clog2(N);
  localparam logic [ROW_BITS-1:0] LAST_ROW = ROW_BITS'(N - 1);

  mpu_ew_state_t       state;
  logic [ROW_BITS-1:0] row;
  logic [N*N*W-1:0]    a_q, b_q;
  logic                op_q, sat_q;

  logic [RW-1:0] row_a, row_b, row_res;
  logic          row_ovf;

  // Active row of the latched operands feeds the single row ALU.
  assign row_a = a_q[row*RW +: RW];
  assign row_b = b_q[row*RW +: RW];

  mpu_row_alu #(.N(N), .W(W), .SIGNED(SIGNED)) u_row_alu (
    .row_a   (row_a),
    .row_b   (row_b),
    .op      (op_q),
    .sat     (sat_q),
    .row_res (row_res),
    .row_ovf (row_ovf)
  );

  // Control FSM with registered outputs; result rows written in RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      row      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= 1'b0;
      sat_q    <= 1'b0;
      result   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // done may be high here from the previous op; a start in this
          // cycle still launches, giving back-to-back operation.
          done <= 1'b0;
          if (start) begin
            a_q      <= matrix_a;
            b_q      <= matrix_b;
            op_q     <= op;
            sat_q    <= sat;
            overflow <= 1'b0;
            row      <= '0;
            busy     <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          result[row*RW +: RW] <= row_res;
          overflow             <= overflow | row_ovf;
          if (row == LAST_ROW) state <= DONE;
          else                 row   <= row + 1'b1;
        end
        DONE: begin
          // start is not looked at here, so it cannot launch early.
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mpu_elementwise_engine.sv
// Bench for mpu_elementwise_engine: an unsigned and a signed instance,
// a vector table replayed through a scoreboard, then multi-cycle corners.
module tb_mpu_elementwise_engine;

  localparam int N   = 5;
  localparam int W   = 8;
  localparam int TOT = N * N * W;

  typedef logic [TOT-1:0] mat_t;

  typedef struct {
    string      name;
    logic       sgn;
    mat_t       a;
    mat_t       b;
    logic       op;
    logic       sat;
    mat_t       exp_res;
    logic       exp_ovf;
    logic       has_el;
    int         el_i;
    int         el_j;
    logic [7:0] el_v;
  } vec_t;

  typedef struct {
    mat_t res;
    logic ovf;
  } sb_t;

  logic clk = 1'b0;
  logic rst_n;
  logic u_start, u_op, u_sat, u_busy, u_done, u_ovf;
  logic s_start, s_op, s_sat, s_busy, s_done, s_ovf;
  mat_t u_a, u_b, u_res, s_a, s_b, s_res;

  sb_t  sbq[$];
  vec_t vecs[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  always #5 clk = ~clk;

  mpu_elementwise_engine #(.N(N), .W(W), .SIGNED(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(u_start), .op(u_op), .sat(u_sat),
    .matrix_a(u_a), .matrix_b(u_b), .result(u_res),
    .busy(u_busy), .done(u_done), .overflow(u_ovf)
  );

  mpu_elementwise_engine #(.N(N), .W(W), .SIGNED(1)) s_dut (
    .clk(clk), .rst_n(rst_n), .start(s_start), .op(s_op), .sat(s_sat),
    .matrix_a(s_a), .matrix_b(s_b), .result(s_res),
    .busy(s_busy), .done(s_done), .overflow(s_ovf)
  );

  task automatic check(input string name, input mat_t act, input mat_t exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic check_i(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic mat_t set_el(input mat_t m, input int i, input int j,
                                  input logic [7:0] v);
    mat_t r;
    r = m;
    r[(i*N+j)*W +: W] = v;
    return r;
  endfunction

  function automatic mat_t fill(input logic [7:0] v);
    mat_t r;
    for (int k = 0; k < N*N; k++) r[k*W +: W] = v;
    return r;
  endfunction

  function automatic mat_t pattern();
    mat_t r;
    for (int k = 0; k < N*N; k++) r[k*W +: W] = 8'(k);
    return r;
  endfunction

  // Integer reference: exact result, range check, then clamp or wrap.
  task automatic model(input logic sgn, input mat_t a, input mat_t b,
                       input logic op, input logic sat,
                       output mat_t res, output logic ovf);
    res = '0;
    ovf = 1'b0;
    for (int k = 0; k < N*N; k++) begin
      logic [7:0] ae, be, re;
      int x, y, r, lo, hi;
      ae = a[k*W +: W];
      be = b[k*W +: W];
      if (sgn) begin
        x = int'($signed(ae)); y = int'($signed(be)); lo = -128; hi = 127;
      end else begin
        x = int'(ae); y = int'(be); lo = 0; hi = 255;
      end
      r = op ? (x - y) : (x + y);
      if (r < lo) begin
        ovf = 1'b1;
        if (sat) r = lo;
      end else if (r > hi) begin
        ovf = 1'b1;
        if (sat) r = hi;
      end
      re = r[7:0];
      res[k*W +: W] = re;
    end
  endtask

  task automatic mk(input string name, input logic sgn, input mat_t a,
                    input mat_t b, input logic op, input logic sat,
                    input logic has_el, input int ei, input int ej,
                    input logic [7:0] ev);
    vec_t v;
    v.name = name; v.sgn = sgn; v.a = a; v.b = b; v.op = op; v.sat = sat;
    v.has_el = has_el; v.el_i = ei; v.el_j = ej; v.el_v = ev;
    model(sgn, a, b, op, sat, v.exp_res, v.exp_ovf);
    vecs.push_back(v);
  endtask

  task automatic drive(input vec_t v, input logic st);
    if (v.sgn) begin
      s_a = v.a; s_b = v.b; s_op = v.op; s_sat = v.sat; s_start = st;
    end else begin
      u_a = v.a; u_b = v.b; u_op = v.op; u_sat = v.sat; u_start = st;
    end
  endtask

  task automatic push_exp(input vec_t v);
    sb_t e;
    e.res = v.exp_res;
    e.ovf = v.exp_ovf;
    sbq.push_back(e);
  endtask

  // Called at a negedge: start is seen by the next edge (edge 0), then dropped.
  task automatic launch(input vec_t v);
    push_exp(v);
    drive(v, 1'b1);
    @(posedge clk);
    @(negedge clk);
    if (v.sgn) s_start = 1'b0;
    else       u_start = 1'b0;
  endtask

  // Counts edges until done is seen (bounded); busy must hold until then.
  task automatic wait_done(input logic sgn, output int edges, output int busy_ok);
    edges   = -1;
    busy_ok = 1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (sgn ? s_done : u_done) begin
        edges = k;
        break;
      end
      if (!(sgn ? s_busy : u_busy)) busy_ok = 0;
    end
  endtask

  // Waits for done, then pops the scoreboard and compares.
  task automatic finish_op(input logic sgn, input int exp_edges, input string name);
    int   edges, busy_ok;
    sb_t  e;
    wait_done(sgn, edges, busy_ok);
    check_i({name, " latency"}, edges, exp_edges);
    check_i({name, " busy"}, busy_ok, 1);
    if (sbq.size() == 0) begin
      check_i({name, " scoreboard"}, 0, 1);
    end else begin
      e = sbq.pop_front();
      if (edges > 0) begin
        check({name, " result"}, sgn ? s_res : u_res, e.res);
        check_i({name, " overflow"}, int'(sgn ? s_ovf : u_ovf), int'(e.ovf));
      end
    end
  endtask

  function automatic logic [7:0] el(input mat_t m, input int i, input int j);
    return m[(i*N+j)*W +: W];
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far",
             pass_cnt, total_cnt);
    $fatal(1);
  end

  initial begin
    mat_t a1, b1, sa, sb;
    vec_t v;
    int   edges, busy_ok, extra;

    u_start = 0; u_op = 0; u_sat = 0; u_a = '0; u_b = '0;
    s_start = 0; s_op = 0; s_sat = 0; s_a = '0; s_b = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #11;
    check("reset u result", u_res, '0);
    check_i("reset u ctrl", int'({u_busy, u_done, u_ovf}), 0);
    check("reset s result", s_res, '0);
    check_i("reset s ctrl", int'({s_busy, s_done, s_ovf}), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Vector table.
    a1 = set_el(pattern(), 2, 3, 8'd250);
    b1 = set_el(fill(8'd1), 2, 3, 8'd10);
    sa = set_el(set_el(fill(8'd0), 0, 0, 8'h80), 4, 4, 8'd100);
    sb = set_el(set_el(fill(8'd0), 0, 0, 8'd1), 4, 4, 8'hCE);
    mk("u add inc",      0, pattern(), fill(8'd1), 0, 0, 1, 4, 4, 8'd25);
    mk("u add wrap",     0, a1, b1, 0, 0, 1, 2, 3, 8'd4);
    mk("u add sat",      0, a1, b1, 0, 1, 1, 2, 3, 8'd255);
    mk("u sub wrap",     0, pattern(), fill(8'd3), 1, 0, 1, 0, 1, 8'hFE);
    mk("u sub sat",      0, pattern(), fill(8'd3), 1, 1, 1, 0, 1, 8'd0);
    mk("u sub ok",       0, fill(8'd200), pattern(), 1, 0, 1, 4, 4, 8'd176);
    mk("s sub sat lo",   1, sa, sb, 1, 1, 1, 0, 0, 8'h80);
    mk("s sub sat hi",   1, sa, sb, 1, 1, 1, 4, 4, 8'h7F);
    mk("s add wrap",     1, fill(8'd100), fill(8'd100), 0, 0, 1, 1, 1, 8'hC8);
    mk("s sub zero",     1, pattern(), pattern(), 1, 0, 1, 3, 3, 8'd0);

    foreach (vecs[i]) begin
      @(negedge clk);
      launch(vecs[i]);
      finish_op(vecs[i].sgn, N + 1, vecs[i].name);
      if (vecs[i].has_el)
        check_i({vecs[i].name, " element"},
                int'(el(vecs[i].sgn ? s_res : u_res, vecs[i].el_i, vecs[i].el_j)),
                int'(vecs[i].el_v));
    end

    // Operands change after start and start re-pulses mid-RUN.
    @(negedge clk);
    launch(vecs[0]);
    u_a = fill(8'hFF);
    @(posedge clk);
    @(negedge clk);
    u_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    u_start = 1'b0;
    finish_op(1'b0, N - 1, "midrun");
    extra = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (u_done) extra++;
    end
    check_i("midrun extra done", extra, 0);

    // start held across done: second op launches right after the done cycle.
    @(negedge clk);
    push_exp(vecs[1]);
    drive(vecs[1], 1'b1);
    @(posedge clk);
    @(negedge clk);
    drive(vecs[0], 1'b1);
    finish_op(1'b0, N + 1, "b2b op1");
    push_exp(vecs[0]);
    @(posedge clk);
    @(negedge clk);
    u_start = 1'b0;
    check_i("b2b accept ctrl", int'({u_busy, u_done, u_ovf}), 4);
    finish_op(1'b0, N + 1, "b2b op2");

    // Reset while row 2 is the active row.
    @(negedge clk);
    drive(vecs[1], 1'b1);
    @(posedge clk);
    @(negedge clk);
    u_start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort result", u_res, '0);
    check_i("abort ctrl", int'({u_busy, u_done, u_ovf}), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    extra = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (u_done || u_busy) extra++;
    end
    check_i("abort no done", extra, 0);
    @(negedge clk);
    launch(vecs[0]);
    finish_op(1'b0, N + 1, "after abort");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/mpu_elementwise_engine.md
Name: mpu_elementwise_engine

Overview:
- Sequential, parametrised matrix element-wise engine for the MPU; successor to the fixed 5x5, 8-bit, add-only combinational adder.
- Captures two N x N matrices on a start handshake and processes one row per clock.
- Supports add or subtract, optional saturation, signed or unsigned arithmetic, and reports overflow.
- Sits between the MPU operand register file and the result writeback.

Parameters:
- N, 5, matrix dimension (rows = cols = N); legal 2..8
- W, 8, element width in bits
- SIGNED, 0, 1 = two's-complement elements, 0 = unsigned

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; accepted only when busy=0
- op  in  1  0 = add (a+b), 1 = subtract (a-b); sampled with start
- sat  in  1  1 = saturate, 0 = wrap modulo 2^W; sampled with start
- matrix_a  in  N*N*W  flat operand A; element [i][j] at bits ((i*N+j)*W) +: W
- matrix_b  in  N*N*W  flat operand B; same packing
- result  out  N*N*W  flat result; same packing
- busy  out  1  high from the accepting edge until done
- done  out  1  one-cycle pulse; result is complete
- overflow  out  1  sticky per operation; some element over/underflowed

Behaviour:
- Reset (async, rst_n=0): state IDLE; result all zero; busy, done and overflow 0; row index 0; internal operand and control registers zero.
- FSM states IDLE, RUN, DONE.
- IDLE, start=1 on an edge:
  - latch matrix_a, matrix_b, op and sat into internal registers;
  - clear overflow; row=0; busy=1; go to RUN.
  - Inputs may change freely after this edge.
- RUN, each edge:
  - compute row `row` from the latched operands;
  - write its N elements into result[row];
  - OR the row's overflow into overflow.
  - row<N-1: row++. row=N-1: go to DONE.
- DONE, one edge: busy=0, done=1 for exactly one cycle; go to IDLE.
- Latency: the start edge is edge 0. Rows are written on edges 1..N. done is high in the cycle after edge N+1.
- start while busy=1 is ignored with no side effect. start during the DONE cycle is also ignored.
- start may be asserted in the same cycle done is high; it is accepted on the next edge, which gives back-to-back operation.
- result is updated row by row during RUN and is valid only from done until the next accepted start. Rows not yet rewritten keep their old values.
- Arithmetic: compute at W+1 bits per element.
  - Unsigned: overflow if add carries out, or if subtract borrows (a<b).
  - Signed: overflow if operand signs match (add) or differ (sub) and the result sign differs from a.
  - sat=1: clamp to max/min (unsigned 2^W-1 / 0; signed 2^(W-1)-1 / -2^(W-1)).
  - sat=0: low W bits.
  - overflow is reported in both modes.
- Reset mid-operation: immediately back to IDLE, all outputs zeroed. No done is issued for the aborted operation.

Decomposition:
- Shared package mpu_pkg holds:
  - op encodings MPU_OP_ADD=1'b0, MPU_OP_SUB=1'b1;
  - state typedef mpu_ew_state_t {IDLE, RUN, DONE};
  - element min/max helper functions parametrised on W and SIGNED.
- One combinational sub-module, mpu_row_alu (params N, W, SIGNED):
  - inputs: one row of a and b, op, sat;
  - outputs: the N result elements and an OR-reduced row overflow.
  - The engine instantiates it once and muxes the active row in.

Test Plan:
- N=5, W=8, unsigned, add, wrap: a[i][j]=i*5+j, b=all 1 -> result[i][j]=i*5+j+1; done exactly 6 edges after the start edge; overflow=0.
- Unsigned add, a[2][3]=250, b[2][3]=10:
  - sat=0 -> result[2][3]=4, overflow=1;
  - sat=1 -> 255, overflow=1;
  - all other elements are unaffected.
- SIGNED=1, sub, sat=1: a[0][0]=-128, b[0][0]=1 -> -128 (0x80), overflow=1; a[4][4]=100, b[4][4]=-50 -> 127.
- Change matrix_a to all 0xFF one cycle after start, and pulse start again mid-RUN -> result matches the originally latched operands; only one done pulse; busy stays high throughout.
- Start held high across done -> second operation begins immediately after the done cycle; overflow from op 1 (=1) is cleared when op 2 (no overflow) is accepted.
- rst_n low at row 2 of RUN -> result, busy, done and overflow are 0 immediately; no done pulse; a subsequent start completes normally.
